bp_update_arbiter: RTL and testbench
====================================

Name: bp_update_arbiter

Overview:
- Sits between the branch-resolution sources and the branch predictor's single feedback port.
- Accepts resolved-branch outcomes from two requesters: port 0 is ROB commit, port 1 is ALU early resolve.
- Queues the outcomes in a small FIFO and drains exactly one per enabled cycle into the predictor's update interface (update-enable, actually-taken, then-pc).
- Keeps saturating counters of total updates and mispredictions for performance debug.

Parameters:
- DAT_W, 32, width of pc.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, 32, width of each statistics counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  global enable (low = pipeline stall); gates draining only.
- r0_valid_i  in  1  port 0 outcome valid.
- r0_ready_o  out  1  port 0 accepted this cycle.
- r0_abr_i  in  1  port 0 actually branched.
- r0_pred_i  in  1  port 0 predicted-taken bit.
- r0_pc_i  in  DAT_W  port 0 branch pc.
- r1_valid_i, r1_ready_o, r1_abr_i, r1_pred_i, r1_pc_i  same as port 0, for port 1.
- bp_en_o  out  1  predictor update strobe.
- bp_abr_o  out  1  taken outcome to predictor.
- bp_tpc_o  out  DAT_W  pc to predictor.
- cnt_o  out  clog2(DEPTH)+1  current FIFO occupancy.
- full_o  out  1  cnt_o == DEPTH.
- empty_o  out  1  cnt_o == 0.
- clr_stat_i  in  1  synchronous clear of both statistics counters.
- upd_cnt_o  out  CNT_W  total updates issued.
- mis_cnt_o  out  CNT_W  updates where pred != abr.

Behaviour:
- Reset (rst_n low, async): FIFO empty, pointers 0, cnt_o=0, empty_o=1, full_o=0, bp_en_o=0, bp_abr_o=0, bp_tpc_o=0, upd_cnt_o=0, mis_cnt_o=0. Reset mid-operation discards all queued entries.
- Free slots: free = DEPTH - cnt_o, taken from the registered count. A pop in the same cycle does not create room.
- Ready (combinational):
  - r0_ready_o = (free >= 1).
  - r1_ready_o = (free >= 2) if r0_valid_i, else (free >= 1).
  - Port 0 has fixed priority.
- Push: a port pushes on the edge where its valid and ready are both high. If both push, port 0's entry is written before port 1's (program order), using two consecutive slots. Each entry stores {abr, pred, pc}.
- Pushes are accepted regardless of en.
- Pop: occurs on the edge where en=1 and cnt_o>0. Exactly one entry per edge, oldest first.
- Output registers:
  - On a pop edge: bp_en_o<=1, bp_abr_o<=entry.abr, bp_tpc_o<=entry.pc.
  - Otherwise: bp_en_o<=0, and bp_abr_o/bp_tpc_o hold their previous values.
  - bp_en_o is never high for two cycles carrying the same entry.
- Latency: an entry pushed at edge k into an empty FIFO pops at edge k+1. bp_en_o is high during the cycle after edge k+1.
- Occupancy: cnt_o next = cnt_o + pushes - pop, where pushes is 0, 1 or 2. Pointers wrap modulo DEPTH. Simultaneous push and pop at full is impossible by the ready rule; at empty, pop is suppressed.
- en low: FIFO holds its contents, no pop, bp_en_o=0. The FIFO can fill and back-pressure via ready.
- Statistics: on each pop edge, upd_cnt_o increments, and mis_cnt_o increments if entry.pred != entry.abr. Both counters saturate at all-ones.
- clr_stat_i: zeroes both counters on the next edge and overrides any same-edge increment. FIFO contents are unaffected.
- Ordering guarantee: updates reach the predictor in acceptance order; within a cycle, port 0 precedes port 1.

Test Plan:
- Reset then single push: r0 valid with pc=0x104, abr=1, pred=1 at edge 1 -> bp_en_o=1 with bp_tpc_o=0x104 and bp_abr_o=1 after edge 2 only; upd_cnt_o=1, mis_cnt_o=0.
- Dual push: both ports valid, empty FIFO, r0 pc=0x10, r1 pc=0x20 -> both ready; next two drain cycles show 0x10 then 0x20; cnt_o sequence 2,1,0.
- Back-pressure: DEPTH=4, en=0, push 3 entries, then both ports valid -> r0_ready_o=1, r1_ready_o=0; after that edge full_o=1 and both readies 0.
- Stall/resume: FIFO full with en=0 for 5 cycles -> bp_en_o stays 0, cnt_o=4; raise en -> four consecutive bp_en_o pulses in FIFO order, then empty_o=1.
- Mispredict count and clear: drain 3 entries with (pred,abr) = (1,0), (0,0), (0,1) -> mis_cnt_o=2, upd_cnt_o=3; pulse clr_stat_i on the same edge as a 4th pop -> both counters read 0.
- Async reset mid-drain: drop rst_n between edges with cnt_o=3 -> outputs go immediately to reset values, with no further bp_en_o pulses after release.

Source files
------------

// File: rtl/bp_update_arbiter_if.sv
// Resolved-branch requester ports plus the predictor feedback port of bp_update_arbiter.
// Handshake: a requester entry is accepted on a rising edge where its valid and ready are both high; ready never depends on the same port's valid.
interface bp_update_arbiter_if #(
  parameter int DAT_W = 32
);
  logic             r0_valid_i;
  logic             r0_ready_o;
  logic             r0_abr_i;
  logic             r0_pred_i;
  logic [DAT_W-1:0] r0_pc_i;
  logic             r1_valid_i;
  logic             r1_ready_o;
  logic             r1_abr_i;
  logic             r1_pred_i;
  logic [DAT_W-1:0] r1_pc_i;
  logic             bp_en_o;
  logic             bp_abr_o;
  logic [DAT_W-1:0] bp_tpc_o;

  modport slave (
    input  r0_valid_i, r0_abr_i, r0_pred_i, r0_pc_i,
    input  r1_valid_i, r1_abr_i, r1_pred_i, r1_pc_i,
    output r0_ready_o, r1_ready_o,
    output bp_en_o, bp_abr_o, bp_tpc_o
  );

  modport master (
    output r0_valid_i, r0_abr_i, r0_pred_i, r0_pc_i,
    output r1_valid_i, r1_abr_i, r1_pred_i, r1_pc_i,
    input  r0_ready_o, r1_ready_o,
    input  bp_en_o, bp_abr_o, bp_tpc_o
  );
endinterface

// File: rtl/bp_update_arbiter.sv
// Two-port resolved-branch arbiter: queues outcomes in a small FIFO (port 0 first)
// and drains one per enabled cycle into the predictor update port, with saturating stats.
module bp_update_arbiter #(
  parameter int DAT_W = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       clr_stat_i,
  bp_update_arbiter_if.slave         bus,
  output logic [$clog2(DEPTH):0]     cnt_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [CNT_W-1:0]           upd_cnt_o,
  output logic [CNT_W-1:0]           mis_cnt_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DAT_W + 2;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Entry layout: {abr, pred, pc}
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] free;
  logic          push0, push1, pop;
  logic [EW-1:0] e0, e1, head;
  logic          mis;

  // Room is judged on the registered count only; a same-cycle pop does not help.
  assign free           = DEPTH_C - cnt_o;
  assign bus.r0_ready_o = (free >= CW'(1));
  assign bus.r1_ready_o = bus.r0_valid_i ? (free >= CW'(2)) : (free >= CW'(1));

  assign push0 = bus.r0_valid_i & bus.r0_ready_o;
  assign push1 = bus.r1_valid_i & bus.r1_ready_o;
  assign pop   = en & (cnt_o != '0);

  assign e0   = {bus.r0_abr_i, bus.r0_pred_i, bus.r0_pc_i};
  assign e1   = {bus.r1_abr_i, bus.r1_pred_i, bus.r1_pc_i};
  assign head = mem[rd_ptr];
  assign mis  = head[DAT_W+1] ^ head[DAT_W];

  assign full_o  = (cnt_o == DEPTH_C);
  assign empty_o = (cnt_o == '0);

  // Port 1 lands in the slot after port 0 when both push together.
  always_ff @(posedge clk) begin
    if (push0) mem[wr_ptr] <= e0;
    if (push1) mem[push0 ? wr_ptr + AW'(1) : wr_ptr] <= e1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_o  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push0) + AW'(push1);
      rd_ptr <= rd_ptr + AW'(pop);
      cnt_o  <= cnt_o + CW'(push0) + CW'(push1) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.bp_en_o  <= 1'b0;
      bus.bp_abr_o <= 1'b0;
      bus.bp_tpc_o <= '0;
    end else begin
      bus.bp_en_o <= pop;
      if (pop) begin
        bus.bp_abr_o <= head[DAT_W+1];
        bus.bp_tpc_o <= head[DAT_W-1:0];
      end
    end
  end

  // Clear wins over a same-edge increment; both counters stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_cnt_o <= '0;
      mis_cnt_o <= '0;
    end else if (clr_stat_i) begin
      upd_cnt_o <= '0;
      mis_cnt_o <= '0;
    end else if (pop) begin
      if (upd_cnt_o != '1) upd_cnt_o <= upd_cnt_o + CNT_W'(1);
      if (mis && (mis_cnt_o != '1)) mis_cnt_o <= mis_cnt_o + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_bp_update_arbiter.sv
// Directed bench for bp_update_arbiter: cycle vector table plus hand sequences for
// async reset mid-drain and counter saturation (second instance with 2-bit counters).
module tb_bp_update_arbiter;
  logic clk;
  logic rst_n;
  logic en;
  logic clr_stat;
  logic [2:0]  cnt, cnt2;
  logic        full, empty, full2, empty2;
  logic [31:0] upd, mis;
  logic [1:0]  upd2, mis2;
  int total;
  int bad;

  bp_update_arbiter_if #(.DAT_W(32)) ifc ();
  bp_update_arbiter_if #(.DAT_W(32)) ifc2 ();

  bp_update_arbiter #(.DAT_W(32), .DEPTH(4), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr_stat_i(clr_stat), .bus(ifc),
    .cnt_o(cnt), .full_o(full), .empty_o(empty), .upd_cnt_o(upd), .mis_cnt_o(mis)
  );

  bp_update_arbiter #(.DAT_W(32), .DEPTH(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .clr_stat_i(clr_stat), .bus(ifc2),
    .cnt_o(cnt2), .full_o(full2), .empty_o(empty2), .upd_cnt_o(upd2), .mis_cnt_o(mis2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic en; logic r0v; logic r0a; logic r0p; logic [31:0] r0pc;
    logic r1v; logic r1a; logic r1p; logic [31:0] r1pc; logic clr;
    logic x_r0rdy; logic x_r1rdy; logic x_bpen; logic x_abr; logic [31:0] x_tpc;
    logic [2:0] x_cnt; logic [31:0] x_upd; logic [31:0] x_mis;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mk(
    input logic e, input logic r0v, input logic r0a, input logic r0p, input logic [31:0] r0pc,
    input logic r1v, input logic r1a, input logic r1p, input logic [31:0] r1pc, input logic clr,
    input logic xr0, input logic xr1, input logic xen, input logic xabr, input logic [31:0] xtpc,
    input logic [2:0] xcnt, input logic [31:0] xupd, input logic [31:0] xmis);
    vec_t v;
    v.en = e; v.r0v = r0v; v.r0a = r0a; v.r0p = r0p; v.r0pc = r0pc;
    v.r1v = r1v; v.r1a = r1a; v.r1p = r1p; v.r1pc = r1pc; v.clr = clr;
    v.x_r0rdy = xr0; v.x_r1rdy = xr1; v.x_bpen = xen; v.x_abr = xabr; v.x_tpc = xtpc;
    v.x_cnt = xcnt; v.x_upd = xupd; v.x_mis = xmis;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    ifc.r0_valid_i = 0; ifc.r0_abr_i = 0; ifc.r0_pred_i = 0; ifc.r0_pc_i = '0;
    ifc.r1_valid_i = 0; ifc.r1_abr_i = 0; ifc.r1_pred_i = 0; ifc.r1_pc_i = '0;
    clr_stat = 0;
  endtask

  task automatic step(input vec_t v, input int idx);
    @(negedge clk);
    en = v.en; clr_stat = v.clr;
    ifc.r0_valid_i = v.r0v; ifc.r0_abr_i = v.r0a; ifc.r0_pred_i = v.r0p; ifc.r0_pc_i = v.r0pc;
    ifc.r1_valid_i = v.r1v; ifc.r1_abr_i = v.r1a; ifc.r1_pred_i = v.r1p; ifc.r1_pc_i = v.r1pc;
    #1;
    chk($sformatf("v%0d_r0_ready", idx), 32'(ifc.r0_ready_o), 32'(v.x_r0rdy));
    chk($sformatf("v%0d_r1_ready", idx), 32'(ifc.r1_ready_o), 32'(v.x_r1rdy));
    @(posedge clk);
    #1;
    chk($sformatf("v%0d_bp_en", idx), 32'(ifc.bp_en_o), 32'(v.x_bpen));
    chk($sformatf("v%0d_bp_abr", idx), 32'(ifc.bp_abr_o), 32'(v.x_abr));
    chk($sformatf("v%0d_bp_tpc", idx), ifc.bp_tpc_o, v.x_tpc);
    chk($sformatf("v%0d_cnt", idx), 32'(cnt), 32'(v.x_cnt));
    chk($sformatf("v%0d_full", idx), 32'(full), 32'(v.x_cnt == 3'd4));
    chk($sformatf("v%0d_empty", idx), 32'(empty), 32'(v.x_cnt == 3'd0));
    chk($sformatf("v%0d_upd", idx), upd, v.x_upd);
    chk($sformatf("v%0d_mis", idx), mis, v.x_mis);
  endtask

  initial begin
    int seen;
    total = 0; bad = 0;
    rst_n = 0; en = 0;
    idle_inputs();
    ifc2.r0_valid_i = 0; ifc2.r0_abr_i = 0; ifc2.r0_pred_i = 0; ifc2.r0_pc_i = '0;
    ifc2.r1_valid_i = 0; ifc2.r1_abr_i = 0; ifc2.r1_pred_i = 0; ifc2.r1_pc_i = '0;

    //            en r0v a p pc       r1v a p pc      clr r0r r1r bpen abr tpc      cnt upd mis
    vecs[0]  = mk(1, 1, 1, 1, 'h104, 0, 0, 0, 0,     0,  1,  1,  0,   0,  'h0,   1,  0,  0);
    vecs[1]  = mk(1, 0, 0, 0, 0,     0, 0, 0, 0,     0,  1,  1,  1,   1,  'h104, 0,  1,  0);
    vecs[2]  = mk(1, 0, 0, 0, 0,     0, 0, 0, 0,     0,  1,  1,  0,   1,  'h104, 0,  1,  0);
    vecs[3]  = mk(1, 1, 0, 0, 'h10,  1, 1, 0, 'h20,  0,  1,  1,  0,   1,  'h104, 2,  1,  0);
    vecs[4]  = mk(1, 0, 0, 0, 0,     0, 0, 0, 0,     0,  1,  1,  1,   0,  'h10,  1,  2,  0);
    vecs[5]  = mk(1, 0, 0, 0, 0,     0, 0, 0, 0,     0,  1,  1,  1,   1,  'h20,  0,  3,  1);
    vecs[6]  = mk(1, 0, 0, 0, 0,     0, 0, 0, 0,     0,  1,  1,  0,   1,  'h20,  0,  3,  1);
    vecs[7]  = mk(0, 1, 0, 1, 'h30,  0, 0, 0, 0,     0,  1,  1,  0,   1,  'h20,  1,  3,  1);
    vecs[8]  = mk(0, 1, 0, 0, 'h34,  0, 0, 0, 0,     0,  1,  1,  0,   1,  'h20,  2,  3,  1);
    vecs[9]  = mk(0, 1, 1, 0, 'h38,  0, 0, 0, 0,     0,  1,  1,  0,   1,  'h20,  3,  3,  1);
    vecs[10] = mk(0, 1, 1, 1, 'h3c,  1, 0, 0, 'h40,  0,  1,  0,  0,   1,  'h20,  4,  3,  1);
    vecs[11] = mk(0, 1, 0, 0, 'h44,  1, 0, 0, 'h48,  0,  0,  0,  0,   1,  'h20,  4,  3,  1);
    vecs[12] = mk(0, 0, 0, 0, 0,     0, 0, 0, 0,     0,  0,  0,  0,   1,  'h20,  4,  3,  1);
    vecs[13] = mk(0, 0, 0, 0, 0,     0, 0, 0, 0,     0,  0,  0,  0,   1,  'h20,  4,  3,  1);
    vecs[14] = mk(0, 0, 0, 0, 0,     0, 0, 0, 0,     0,  0,  0,  0,   1,  'h20,  4,  3,  1);
    vecs[15] = mk(0, 0, 0, 0, 0,     0, 0, 0, 0,     0,  0,  0,  0,   1,  'h20,  4,  3,  1);
    vecs[16] = mk(1, 0, 0, 0, 0,     0, 0, 0, 0,     0,  0,  0,  1,   0,  'h30,  3,  4,  2);
    vecs[17] = mk(1, 0, 0, 0, 0,     0, 0, 0, 0,     0,  1,  1,  1,   0,  'h34,  2,  5,  2);
    vecs[18] = mk(1, 0, 0, 0, 0,     0, 0, 0, 0,     0,  1,  1,  1,   1,  'h38,  1,  6,  3);
    vecs[19] = mk(1, 0, 0, 0, 0,     0, 0, 0, 0,     1,  1,  1,  1,   1,  'h3c,  0,  0,  0);
    vecs[20] = mk(1, 0, 0, 0, 0,     0, 0, 0, 0,     0,  1,  1,  0,   1,  'h3c,  0,  0,  0);

    // Reset state
    #12;
    chk("rst_cnt", 32'(cnt), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_bp_en", 32'(ifc.bp_en_o), 32'd0);
    chk("rst_bp_abr", 32'(ifc.bp_abr_o), 32'd0);
    chk("rst_bp_tpc", ifc.bp_tpc_o, 32'd0);
    chk("rst_upd", upd, 32'd0);
    chk("rst_mis", mis, 32'd0);
    @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < 21; i++) step(vecs[i], i);

    // Async reset mid-drain: fill 4, pop one, then reset between edges with cnt=3
    @(negedge clk);
    en = 0;
    ifc.r0_valid_i = 1; ifc.r0_abr_i = 1; ifc.r0_pred_i = 0; ifc.r0_pc_i = 'h50;
    ifc.r1_valid_i = 1; ifc.r1_abr_i = 1; ifc.r1_pred_i = 0; ifc.r1_pc_i = 'h54;
    @(negedge clk);
    ifc.r0_pc_i = 'h58; ifc.r1_pc_i = 'h5c;
    @(negedge clk);
    idle_inputs();
    en = 1;
    @(posedge clk);
    #1;
    chk("ar_pre_cnt", 32'(cnt), 32'd3);
    chk("ar_pre_bp_en", 32'(ifc.bp_en_o), 32'd1);
    chk("ar_pre_tpc", ifc.bp_tpc_o, 32'h50);
    chk("ar_pre_upd", upd, 32'd1);
    #2;
    rst_n = 0;
    #1;
    chk("ar_cnt", 32'(cnt), 32'd0);
    chk("ar_empty", 32'(empty), 32'd1);
    chk("ar_bp_en", 32'(ifc.bp_en_o), 32'd0);
    chk("ar_bp_abr", 32'(ifc.bp_abr_o), 32'd0);
    chk("ar_bp_tpc", ifc.bp_tpc_o, 32'd0);
    chk("ar_upd", upd, 32'd0);
    chk("ar_mis", mis, 32'd0);
    @(negedge clk);
    rst_n = 1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (ifc.bp_en_o) seen++;
    end
    chk("ar_post_pulses", 32'(seen), 32'd0);
    chk("ar_post_cnt", 32'(cnt), 32'd0);

    // Saturation on the 2-bit-counter instance: 5 mispredicted pops
    @(negedge clk);
    ifc2.r0_valid_i = 1; ifc2.r0_abr_i = 0; ifc2.r0_pred_i = 1; ifc2.r0_pc_i = 'h80;
    for (int i = 0; i < 5; i++) @(negedge clk);
    ifc2.r0_valid_i = 0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    chk("sat_upd", 32'(upd2), 32'd3);
    chk("sat_mis", 32'(mis2), 32'd3);
    chk("sat_cnt", 32'(cnt2), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
